// File: rtl/encrypt_cfg_master.sv
`default_nettype none
// ============================================================================
// Module      : encrypt_cfg_master
// Description : AXI4-Lite initiator that programs the lightweight-crypt
//               config register bank: soft reset, key1..4, nonce1..4, adlen,
//               plen, then soft reset release. Can read the bank back,
//               compare it, and report the result.
// Ports       : axi_clk / axi_rst    - clock, async active-high reset
//               start / verify_en    - request (IDLE only) and readback enable
//               key, nonce, adlen, plen - values to program
//               busy, done           - sequence in progress / one-cycle end
//               err_code, err_idx    - 00 ok, 01 mismatch, 10 timeout + index
//               aw*/w*/ar*/r*        - AXI-Lite initiator channels (no B)
// Revision    : 1.0 - initial release
// ============================================================================
module encrypt_cfg_master #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pTIMEOUT    = 256
) (
    input  logic                   axi_clk,
    input  logic                   axi_rst,
    input  logic                   start,
    input  logic                   verify_en,
    input  logic [127:0]           key,
    input  logic [127:0]           nonce,
    input  logic [7:0]             adlen,
    input  logic [7:0]             plen,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             err_code,
    output logic [3:0]             err_idx,
    output logic                   awvalid,
    output logic [pADDR_WIDTH-1:0] awaddr,
    output logic                   wvalid,
    output logic [pDATA_WIDTH-1:0] wdata,
    output logic [3:0]             wstrb,
    input  logic                   awready,
    input  logic                   wready,
    output logic                   arvalid,
    output logic [pADDR_WIDTH-1:0] araddr,
    input  logic                   arready,
    input  logic                   rvalid,
    input  logic [pDATA_WIDTH-1:0] rdata,
    output logic                   rready
);

    localparam int         c_CNT_W    = (pTIMEOUT > 2) ? $clog2(pTIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_TO_MAX = c_CNT_W'(pTIMEOUT - 1);
    localparam logic [3:0] c_LAST_WR  = 4'd11;
    localparam logic [3:0] c_LAST_RD  = 4'd10;
    localparam logic [1:0] c_ERR_OK   = 2'b00;
    localparam logic [1:0] c_ERR_MISM = 2'b01;
    localparam logic [1:0] c_ERR_TO   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR      = 3'd1,
        S_RD_ADDR = 3'd2,
        S_RD_DATA = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t               r_state;
    logic [3:0]           r_idx;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_aw_done;
    logic                 r_w_done;
    logic                 r_verify;
    logic [127:0]         r_key;
    logic [127:0]         r_nonce;
    logic [7:0]           r_adlen;
    logic [7:0]           r_plen;

    logic                   w_aw_hs;
    logic                   w_w_hs;
    logic                   w_aw_ok;
    logic                   w_w_ok;
    logic                   w_timeout;
    logic [3:0]             w_idx_nxt;
    logic [pADDR_WIDTH-1:0] w_nxt_addr;
    logic [31:0]            w_nxt_data;
    logic [31:0]            w_cur_data;

    // Register byte address for a table index; index 11 revisits soft reset.
    function automatic logic [pADDR_WIDTH-1:0] f_addr(input logic [3:0] idx);
        logic [pADDR_WIDTH-1:0] a;
        a = '0;
        if (idx != c_LAST_WR) begin
            a = pADDR_WIDTH'({idx, 2'b00});
        end
        return a;
    endfunction

    // Register contents for a table index, built from the latched copies.
    function automatic logic [31:0] f_data(input logic [3:0]   idx,
                                           input logic [127:0] k,
                                           input logic [127:0] n,
                                           input logic [7:0]   al,
                                           input logic [7:0]   pl);
        logic [31:0] d;
        d = 32'd0;
        case (idx)
            4'd0:    d = 32'd1;
            4'd1:    d = k[127:96];
            4'd2:    d = k[95:64];
            4'd3:    d = k[63:32];
            4'd4:    d = k[31:0];
            4'd5:    d = n[127:96];
            4'd6:    d = n[95:64];
            4'd7:    d = n[63:32];
            4'd8:    d = n[31:0];
            4'd9:    d = {24'd0, al};
            4'd10:   d = {24'd0, pl};
            default: d = 32'd0;
        endcase
        return d;
    endfunction

    assign w_aw_hs    = awvalid & awready;
    assign w_w_hs     = wvalid & wready;
    // A channel counts as accepted if it completed earlier or completes now.
    assign w_aw_ok    = r_aw_done | w_aw_hs;
    assign w_w_ok     = r_w_done | w_w_hs;
    assign w_timeout  = (r_cnt == c_TO_MAX);
    assign w_idx_nxt  = r_idx + 4'd1;
    assign w_nxt_addr = f_addr(w_idx_nxt);
    assign w_nxt_data = f_data(w_idx_nxt, r_key, r_nonce, r_adlen, r_plen);
    assign w_cur_data = f_data(r_idx, r_key, r_nonce, r_adlen, r_plen);

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            r_state   <= S_IDLE;
            r_idx     <= 4'd0;
            r_cnt     <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_verify  <= 1'b0;
            r_key     <= '0;
            r_nonce   <= '0;
            r_adlen   <= '0;
            r_plen    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_code  <= c_ERR_OK;
            err_idx   <= 4'd0;
            awvalid   <= 1'b0;
            awaddr    <= '0;
            wvalid    <= 1'b0;
            wdata     <= '0;
            wstrb     <= 4'h0;
            arvalid   <= 1'b0;
            araddr    <= '0;
            rready    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_key     <= key;
                        r_nonce   <= nonce;
                        r_adlen   <= adlen;
                        r_plen    <= plen;
                        r_verify  <= verify_en;
                        err_code  <= c_ERR_OK;
                        err_idx   <= 4'd0;
                        r_idx     <= 4'd0;
                        r_cnt     <= '0;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        busy      <= 1'b1;
                        awvalid   <= 1'b1;
                        wvalid    <= 1'b1;
                        awaddr    <= f_addr(4'd0);
                        wdata     <= pDATA_WIDTH'(32'd1);
                        wstrb     <= 4'hF;
                        r_state   <= S_WR;
                    end
                end

                S_WR: begin
                    if (w_aw_ok && w_w_ok) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_cnt     <= '0;
                        if (r_idx == c_LAST_WR) begin
                            awvalid <= 1'b0;
                            wvalid  <= 1'b0;
                            if (r_verify) begin
                                // Readback skips index 0; soft reset is self-clearing.
                                r_idx   <= 4'd1;
                                arvalid <= 1'b1;
                                araddr  <= f_addr(4'd1);
                                r_state <= S_RD_ADDR;
                            end else begin
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                r_state <= S_DONE;
                            end
                        end else begin
                            r_idx   <= w_idx_nxt;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            awaddr  <= w_nxt_addr;
                            wdata   <= pDATA_WIDTH'(w_nxt_data);
                        end
                    end else if (w_timeout && !w_aw_hs && !w_w_hs) begin
                        awvalid   <= 1'b0;
                        wvalid    <= 1'b0;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        err_code  <= c_ERR_TO;
                        err_idx   <= r_idx;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        // Only one channel made progress: retire it, keep the other.
                        if (w_aw_hs) begin
                            awvalid   <= 1'b0;
                            r_aw_done <= 1'b1;
                        end
                        if (w_w_hs) begin
                            wvalid   <= 1'b0;
                            r_w_done <= 1'b1;
                        end
                        r_cnt <= (w_aw_hs || w_w_hs) ? '0 : r_cnt + c_CNT_W'(1);
                    end
                end

                S_RD_ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_RD_DATA;
                    end else if (w_timeout) begin
                        arvalid  <= 1'b0;
                        err_code <= c_ERR_TO;
                        err_idx  <= r_idx;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end

                S_RD_DATA: begin
                    if (rvalid) begin
                        rready <= 1'b0;
                        r_cnt  <= '0;
                        // Only the first mismatch is recorded.
                        if ((rdata != pDATA_WIDTH'(w_cur_data)) && (err_code == c_ERR_OK)) begin
                            err_code <= c_ERR_MISM;
                            err_idx  <= r_idx;
                        end
                        if (r_idx == c_LAST_RD) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= w_idx_nxt;
                            arvalid <= 1'b1;
                            araddr  <= w_nxt_addr;
                            r_state <= S_RD_ADDR;
                        end
                    end else if (w_timeout) begin
                        // A timeout replaces any mismatch already recorded.
                        rready   <= 1'b0;
                        err_code <= c_ERR_TO;
                        err_idx  <= r_idx;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_encrypt_cfg_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_encrypt_cfg_master
// Description : Self-checking bench for encrypt_cfg_master. A scenario table
//               drives an AXI-Lite responder model; observed transfers are
//               compared against the register programming order derived
//               from the inputs, plus cycle/err expectations per scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_encrypt_cfg_master;

    logic         axi_clk;
    logic         axi_rst;
    logic         start;
    logic         verify_en;
    logic [127:0] key;
    logic [127:0] nonce;
    logic [7:0]   adlen;
    logic [7:0]   plen;
    logic         busy;
    logic         done;
    logic [1:0]   err_code;
    logic [3:0]   err_idx;
    logic         awvalid;
    logic [11:0]  awaddr;
    logic         wvalid;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         awready;
    logic         wready;
    logic         arvalid;
    logic [11:0]  araddr;
    logic         arready;
    logic         rvalid;
    logic [31:0]  rdata;
    logic         rready;

    logic g_aw, g_w, g_ar;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit         verify;
        bit         corrupt;    // responder returns DEADBEEF for 0x018
        int         mode;       // 0 ideal, 1 random stalls, 2 late wready idx5, 3 no arready
        bit         fixed;      // use the reference key/nonce/lengths
        bit         poke;       // extra start with other key while busy
        logic [1:0] exp_err;
        logic [3:0] exp_idx;
        int         exp_done;   // done cycle relative to start, -1 = any
        int         exp_ar;     // cycles with arvalid high, -1 = any
        int         exp_wonly;  // cycles with wvalid & !awvalid, -1 = any
    } vec_t;

    encrypt_cfg_master #(
        .pADDR_WIDTH (12),
        .pDATA_WIDTH (32),
        .pTIMEOUT    (16)
    ) dut (
        .axi_clk   (axi_clk),
        .axi_rst   (axi_rst),
        .start     (start),
        .verify_en (verify_en),
        .key       (key),
        .nonce     (nonce),
        .adlen     (adlen),
        .plen      (plen),
        .busy      (busy),
        .done      (done),
        .err_code  (err_code),
        .err_idx   (err_idx),
        .awvalid   (awvalid),
        .awaddr    (awaddr),
        .wvalid    (wvalid),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .awready   (awready),
        .wready    (wready),
        .arvalid   (arvalid),
        .araddr    (araddr),
        .arready   (arready),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .rready    (rready)
    );

    // Responder readies follow the valids combinationally when allowed.
    assign awready = awvalid & g_aw;
    assign wready  = wvalid & g_w;
    assign arready = arvalid & g_ar;

    initial axi_clk = 1'b0;
    always #5 axi_clk = ~axi_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference register programming order.
    function automatic logic [11:0] model_waddr(input int i);
        return (i == 11) ? 12'h000 : 12'(4 * i);
    endfunction

    function automatic logic [31:0] model_wdata(input int i, input logic [127:0] k,
                                                input logic [127:0] n,
                                                input logic [7:0] al, input logic [7:0] pl);
        logic [127:0] sh;
        if (i == 0) return 32'd1;
        if (i <= 4) begin
            sh = k >> (32 * (4 - i));
            return sh[31:0];
        end
        if (i <= 8) begin
            sh = n >> (32 * (8 - i));
            return sh[31:0];
        end
        if (i == 9)  return {24'd0, al};
        if (i == 10) return {24'd0, pl};
        return 32'd0;
    endfunction

    task automatic run_scenario(input vec_t v, input int sid);
        logic [127:0] k, n;
        logic [7:0]   al, pl;
        logic [11:0]  aw_q[$];
        logic [31:0]  w_q[$];
        logic [11:0]  ar_q[$];
        int cyc, done_cyc, n_done, n_ar, n_wonly;
        int bad_busy, bad_strb, bad_idle, stall, wwait, nrd, m;
        bit r_pend, g_r, aw_hs, w_hs, ar_hs, r_hs;
        logic [31:0] r_val;

        if (v.fixed) begin
            k  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
            n  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
            al = 8'h10;
            pl = 8'h20;
        end else begin
            k  = {$urandom, $urandom, $urandom, $urandom};
            n  = {$urandom, $urandom, $urandom, $urandom};
            al = 8'($urandom);
            pl = 8'($urandom);
        end

        @(negedge axi_clk);
        key = k; nonce = n; adlen = al; plen = pl;
        verify_en = v.verify;
        start = 1'b1;
        g_aw = 1'b1; g_w = 1'b1; g_ar = 1'b1;
        rvalid = 1'b0;
        cyc = 0; done_cyc = -1; n_done = 0; n_ar = 0; n_wonly = 0;
        bad_busy = 0; bad_strb = 0; bad_idle = 0; stall = 0; wwait = 0;
        r_pend = 1'b0; r_val = 32'd0; g_r = 1'b1;

        while (cyc < 200 && !(done_cyc >= 0 && cyc >= done_cyc + 3)) begin
            @(negedge axi_clk);
            cyc++;
            start = v.poke && (cyc == 5);
            key   = (v.poke && cyc == 5) ? ~k : k;

            // Responder decisions for this cycle.
            case (v.mode)
                1: begin
                    g_aw = (stall >= 6) || ($urandom_range(0, 3) != 0);
                    g_w  = (stall >= 6) || ($urandom_range(0, 3) != 0);
                    g_ar = (stall >= 6) || ($urandom_range(0, 3) != 0);
                    g_r  = (stall >= 6) || ($urandom_range(0, 3) != 0);
                end
                2: begin
                    g_aw = 1'b1; g_ar = 1'b1; g_r = 1'b1;
                    if (w_q.size() == 5) begin
                        if (aw_q.size() == 6) wwait++;
                        g_w = (aw_q.size() == 6) && (wwait >= 3);
                    end else begin
                        g_w = 1'b1;
                    end
                end
                3: begin
                    g_aw = 1'b1; g_w = 1'b1; g_ar = 1'b0; g_r = 1'b1;
                end
                default: begin
                    g_aw = 1'b1; g_w = 1'b1; g_ar = 1'b1; g_r = 1'b1;
                end
            endcase
            rvalid = r_pend && g_r;
            rdata  = r_val;
            #1;

            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            ar_hs = arvalid && arready;
            r_hs  = rvalid && rready;
            if (aw_hs) aw_q.push_back(awaddr);
            if (w_hs)  w_q.push_back(wdata);
            if (r_hs)  r_pend = 1'b0;
            if (ar_hs) begin
                ar_q.push_back(araddr);
                r_pend = 1'b1;
                r_val  = 32'd0;
                m = (aw_q.size() < w_q.size()) ? aw_q.size() : w_q.size();
                for (int i = 0; i < m; i++) begin
                    if (aw_q[i] == araddr) r_val = w_q[i];
                end
                if (v.corrupt && araddr == 12'h018) r_val = 32'hDEADBEEF;
            end
            stall = (aw_hs || w_hs || ar_hs || r_hs) ? 0 : stall + 1;

            if (arvalid) n_ar++;
            if (wvalid && !awvalid) n_wonly++;
            if (wvalid && wstrb != 4'hF) bad_strb++;
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
                if (awvalid || wvalid || arvalid || rready) bad_idle++;
            end
            if (busy !== ((done_cyc < 0) && !done)) bad_busy++;
        end

        chk($sformatf("s%0d_done_count", sid), n_done, 1);
        if (v.exp_done >= 0) chk($sformatf("s%0d_done_cycle", sid), done_cyc, v.exp_done);
        chk($sformatf("s%0d_err_code", sid), err_code, v.exp_err);
        chk($sformatf("s%0d_err_idx", sid), err_idx, v.exp_idx);
        chk($sformatf("s%0d_aw_count", sid), aw_q.size(), 12);
        chk($sformatf("s%0d_w_count", sid), w_q.size(), 12);
        for (int i = 0; i < 12; i++) begin
            if (i < aw_q.size()) chk($sformatf("s%0d_awaddr%0d", sid, i), aw_q[i], model_waddr(i));
            if (i < w_q.size())  chk($sformatf("s%0d_wdata%0d", sid, i), w_q[i], model_wdata(i, k, n, al, pl));
        end
        nrd = (v.verify && v.mode != 3) ? 10 : 0;
        chk($sformatf("s%0d_rd_count", sid), ar_q.size(), nrd);
        for (int i = 0; i < ar_q.size() && i < nrd; i++)
            chk($sformatf("s%0d_araddr%0d", sid, i), ar_q[i], 12'(4 * (i + 1)));
        if (v.exp_ar >= 0)    chk($sformatf("s%0d_arvalid_cycles", sid), n_ar, v.exp_ar);
        if (v.exp_wonly >= 0) chk($sformatf("s%0d_wonly_cycles", sid), n_wonly, v.exp_wonly);
        chk($sformatf("s%0d_busy_profile", sid), bad_busy, 0);
        chk($sformatf("s%0d_wstrb", sid), bad_strb, 0);
        chk($sformatf("s%0d_idle_at_done", sid), bad_idle, 0);
    endtask

    initial begin
        vec_t vecs[10];
        int   nd;

        vecs[0] = '{1'b1, 1'b0, 0, 1'b1, 1'b0, 2'b00, 4'd0, 33, 10, -1};
        vecs[1] = '{1'b0, 1'b0, 0, 1'b0, 1'b0, 2'b00, 4'd0, 13,  0, -1};
        vecs[2] = '{1'b1, 1'b0, 2, 1'b0, 1'b0, 2'b00, 4'd0, 36, 10,  3};
        vecs[3] = '{1'b1, 1'b1, 0, 1'b0, 1'b0, 2'b01, 4'd6, 33, 10, -1};
        vecs[4] = '{1'b1, 1'b0, 3, 1'b0, 1'b0, 2'b10, 4'd1, 29, 16, -1};
        vecs[5] = '{1'b0, 1'b1, 0, 1'b0, 1'b1, 2'b00, 4'd0, 13,  0, -1};
        vecs[6] = '{1'b1, 1'b0, 1, 1'b0, 1'b0, 2'b00, 4'd0, -1, -1, -1};
        vecs[7] = '{1'b1, 1'b0, 1, 1'b0, 1'b1, 2'b00, 4'd0, -1, -1, -1};
        vecs[8] = '{1'b0, 1'b0, 1, 1'b0, 1'b0, 2'b00, 4'd0, -1,  0, -1};
        vecs[9] = '{1'b1, 1'b1, 1, 1'b0, 1'b0, 2'b01, 4'd6, -1, -1, -1};

        axi_rst = 1'b1; start = 1'b0; verify_en = 1'b0;
        key = '0; nonce = '0; adlen = '0; plen = '0;
        g_aw = 1'b1; g_w = 1'b1; g_ar = 1'b1;
        rvalid = 1'b0; rdata = '0;

        repeat (3) @(negedge axi_clk);
        chk("reset_ctrl", {busy, done, err_code, err_idx, awvalid, wvalid, arvalid, rready, wstrb}, 0);
        chk("reset_bus", {awaddr, araddr, wdata}, 0);
        axi_rst = 1'b0;
        @(negedge axi_clk);
        chk("post_reset_idle", {busy, done, awvalid, wvalid, arvalid, rready}, 0);

        for (int s = 0; s < 10; s++) run_scenario(vecs[s], s);

        // Reset pulse in the middle of the idx 7 write.
        @(negedge axi_clk);
        key = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        nonce = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        adlen = 8'h10; plen = 8'h20; verify_en = 1'b1; start = 1'b1;
        g_aw = 1'b1; g_w = 1'b1; g_ar = 1'b1; rvalid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge axi_clk);
            start = 1'b0;
        end
        chk("rst_mid_awaddr_idx7", {awvalid, awaddr}, {1'b1, 12'h01C});
        axi_rst = 1'b1;
        #1;
        chk("rst_mid_async_drop", {awvalid, wvalid, busy, done}, 0);
        @(negedge axi_clk);
        axi_rst = 1'b0;
        nd = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge axi_clk);
            if (done) nd++;
        end
        chk("rst_mid_no_done", nd, 0);
        chk("rst_mid_idle", {busy, awvalid, wvalid, arvalid, rready}, 0);
        run_scenario(vecs[0], 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/encrypt_cfg_master.md
Name: encrypt_cfg_master

Overview:
- AXI4-Lite initiator that programs the lightweight-crypt user project's config register bank. Targets: soft reset, key1..4, nonce1..4, adlen, plen.
- Sits between a local controller (test sequencer or management firmware bridge) and the user project's AXI-Lite responder port.
- On start it performs the full register programming sequence. It can optionally read the registers back and compare them, then reports a pass/fail status.

Parameters:
- pADDR_WIDTH, 12, AXI-Lite address width.
- pDATA_WIDTH, 32, AXI-Lite data width.
- pTIMEOUT, 256, max cycles to wait for any single handshake before abort (must be >= 2).

Ports:
- axi_clk  in  1  sole clock.
- axi_rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- verify_en  in  1  sampled with start; 1 = readback after writes.
- key  in  128  key; key[127:96]->key1 ... key[31:0]->key4.
- nonce  in  128  nonce; nonce[127:96]->nonce1 ... nonce[31:0]->nonce4.
- adlen  in  8  associated-data length.
- plen  in  8  plaintext length.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at sequence end.
- err_code  out  2  00 ok, 01 readback mismatch, 10 timeout; held until next accepted start.
- err_idx  out  4  register index of first mismatch or of the timed-out transfer.
- awvalid, awaddr[11:0], wvalid, wdata[31:0], wstrb[3:0]  out  write address/data channels.
- awready, wready  in  write channel readies.
- arvalid, araddr[11:0]  out  read address channel.
- arready  in  read address ready.
- rvalid, rdata[31:0]  in  read data channel.
- rready  out  read data ready.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal key/nonce/len copies 0.
- Start handling: start in IDLE latches key, nonce, adlen, plen, verify_en; clears err_code and err_idx; enters WR with idx=0.
- start while busy is ignored.
- Write table (idx: byte address, data):
  - 0: 0x000, 1 (assert core soft reset)
  - 1-4: 0x004, 0x008, 0x00C, 0x010, key1..key4
  - 5-8: 0x014, 0x018, 0x01C, 0x020, nonce1..nonce4
  - 9: 0x024, {24'b0, adlen}
  - 10: 0x028, {24'b0, plen}
  - 11: 0x000, 0 (release soft reset)
- wstrb is always 4'hF.
- WR state:
  - awvalid and wvalid rise together in the first WR cycle for each idx.
  - Each valid is held until its own ready is sampled high. A channel already accepted deasserts its valid while the other channel waits.
  - When both channels are accepted (same or different cycles), idx increments and the next write's valids assert the next cycle if ready fires combinationally. Back-to-back rate is one write per cycle.
  - No write-response channel is used.
- After idx 11 completes: if verify_en = 0, go to DONE. Otherwise go to RD_ADDR with idx=1.
- RD_ADDR: arvalid=1 and araddr = table address. On arready, go to RD_DATA.
- RD_DATA: rready=1. On rvalid:
  - Compare rdata with the table data for idx.
  - On the first mismatch, set err_code=01 and err_idx=idx. Later mismatches do not overwrite.
  - All remaining reads still run. idx 10 goes to DONE, otherwise idx+1 goes to RD_ADDR.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Timeout counter:
  - Clears on entering any WR/RD_ADDR/RD_DATA step and on every handshake; increments otherwise.
  - At pTIMEOUT-1 without the pending handshake: drop all valids/rready next cycle, set err_code=10 and err_idx=idx, go to DONE.
  - Timeout overrides a prior mismatch code.
- Simultaneous events: awready and wready in the same cycle as the valids complete the write in that cycle.
- Reset mid-sequence: valids drop asynchronously, state returns to IDLE, and no done pulse is produced.
- araddr and awaddr hold their last value when valid is low; the bench must not check them then.

Test Plan:
- Default path: responder with combinational awready=wready=awvalid&wvalid and rvalid one cycle after the AR handshake; start at cycle 0 with key=0x00112233_44556677_8899AABB_CCDDEEFF, nonce=0x0F0E0D0C_0B0A0908_07060504_03020100, adlen=0x10, plen=0x20, verify_en=1 -> writes on cycles 1-12 with key1=0x00112233 at 0x004 and 0x00000020 at 0x028; reads at cycles 13-32; done at cycle 33; err_code=00.
- verify_en=0 -> last write (addr 0x000, data 0) on cycle 12, done on cycle 13, arvalid never asserted.
- Responder delays wready 3 cycles after awready on idx 5 -> awvalid drops after its handshake, wvalid held with wdata=nonce1 until wready, then sequence continues; err_code=00.
- Responder returns 0xDEADBEEF for address 0x018 only -> err_code=01, err_idx=6; reads through 0x028 still occur; done pulses.
- Responder never asserts arready, pTIMEOUT=16 -> arvalid drops after 16 cycles on idx 1, err_code=10, err_idx=1, one done pulse.
- axi_rst pulsed during idx 7 write -> awvalid=wvalid=0 immediately, busy=0, no done; a fresh start reruns from idx 0.
